// File: rtl/rom_scan_counter.sv
// rom_scan_counter: sweeps every ROM address once per start and reports
// the number of non-zero entries and the sum of all entries.
module rom_scan_counter #(
    parameter int SIZE  = 8,
    parameter int CNT_W = SIZE + 1,
    parameter int SUM_W = 2 * SIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [SIZE-1:0]  rom_addr,
    input  logic [SIZE-1:0]  rom_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic [SUM_W-1:0] sum
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic [SIZE-1:0] LAST = '1;
    state_t state;
    logic   last;
    assign last = rom_addr == LAST;
    // rom_addr is registered, so rom_data is stable for the whole cycle it is sampled in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            sum      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= SCAN;
                    busy     <= 1'b1;
                    rom_addr <= '0;
                    count    <= '0;
                    sum      <= '0;
                end
                SCAN: begin
                    count    <= count + CNT_W'(rom_data != '0);
                    sum      <= sum + SUM_W'(rom_data);
                    rom_addr <= last ? rom_addr : rom_addr + SIZE'(1);
                    state    <= last ? DONE : SCAN;
                    busy     <= !last;
                    done     <= last;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_scan_counter.sv
// tb_rom_scan_counter: drives rom_scan_counter from a behavioural ROM array and
// compares count/sum, timing and address order against totals computed from that array.
module tb_rom_scan_counter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        busy;
    logic        done;
    logic [8:0]  count;
    logic [15:0] sum;
    logic [7:0]  rom [256];
    int          n_cmp = 0;
    int          n_err = 0;

    rom_scan_counter dut (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .busy(busy), .done(done), .count(count), .sum(sum)
    );

    assign rom_data = rom[rom_addr];
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_count();
        int c = 0;
        foreach (rom[i]) c += (rom[i] != 0) ? 1 : 0;
        return c;
    endfunction

    function automatic int exp_sum();
        int s = 0;
        foreach (rom[i]) s += int'(rom[i]);
        return s;
    endfunction

    task automatic load_real();
        foreach (rom[i]) rom[i] = 8'h00;
        rom[0] = 1; rom[17] = 1; rom[64] = 1; rom[100] = 1;
        rom[128] = 1; rom[200] = 1; rom[255] = 1;
    endtask

    task automatic load_random(input int dens);
        foreach (rom[i]) rom[i] = ($urandom_range(99) < dens) ? 8'($urandom) : 8'h00;
    endtask

    task automatic run_scan(input string tag, input bit inject);
        int busy_n = 0, done_n = 0, done_at = -1, addr_err = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 262; c++) begin
            if (busy) begin
                if (rom_addr != busy_n[7:0]) addr_err++;
                busy_n++;
            end
            if (done) begin
                done_n++;
                done_at = c;
            end
            start = inject && (c == 5 || c == 200 || c == 256);
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, " busy_cycles"}, busy_n, 256);
        chk({tag, " done_pulses"}, done_n, 1);
        chk({tag, " done_cycle"}, done_at, 256);
        chk({tag, " addr_order"}, addr_err, 0);
        chk({tag, " addr_hold"}, rom_addr, 255);
        chk({tag, " count"}, count, exp_count());
        chk({tag, " sum"}, sum, exp_sum());
    endtask

    initial begin
        int dones[$];
        load_real();
        repeat (2) @(negedge clk);
        chk("rst addr", rom_addr, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst count", count, 0);
        chk("rst sum", sum, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle busy", busy, 0);

        run_scan("T1", 1'b0);
        chk("T1 count7", count, 7);
        chk("T1 sum7", sum, 7);
        repeat (4) @(negedge clk);
        chk("T1 hold count", count, 7);
        chk("T1 hold sum", sum, 7);

        foreach (rom[i]) rom[i] = 8'hFF;
        run_scan("T2", 1'b0);
        chk("T2 count", count, 9'h100);
        chk("T2 sum", sum, 16'hFF00);

        foreach (rom[i]) rom[i] = 8'(i);
        run_scan("T3", 1'b0);
        chk("T3 count", count, 255);
        chk("T3 sum", sum, 32640);

        load_real();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("T4 addr", rom_addr, 0);
        chk("T4 busy", busy, 0);
        chk("T4 done", done, 0);
        chk("T4 count", count, 0);
        chk("T4 sum", sum, 0);
        @(negedge clk); rst = 1'b0;
        run_scan("T4 rescan", 1'b0);

        run_scan("T5", 1'b1);

        for (int t = 0; t < 4; t++) begin
            load_random(int'($urandom_range(100)));
            run_scan("RND", t[0]);
        end

        load_random(60);
        @(negedge clk); start = 1'b1;
        for (int c = 0; c < 1000 && dones.size() < 3; c++) begin
            @(negedge clk);
            if (done) begin
                dones.push_back(c);
                chk("T6 count", count, exp_count());
                chk("T6 sum", sum, exp_sum());
            end
        end
        start = 1'b0;
        chk("T6 pulses", dones.size(), 3);
        if (dones.size() == 3) begin
            chk("T6 gap1", dones[1] - dones[0], 258);
            chk("T6 gap2", dones[2] - dones[1], 258);
        end
        repeat (3) @(negedge clk);
        chk("T6 idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
